// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the byte-stream program loader.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte link plus instruction-memory write port of the program loader.
interface prog_loader_if #(
  parameter int AW = 4,
  parameter int IW = 32
);

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output cpu_rst, done, err
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// MSB-first 8-to-32 packer; word_done/word are valid in the cycle
// the last byte of a word is presented, so the caller registers them.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_done,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sh;
  logic [1:0]  idx;

  assign word_done = en && (idx == LAST_IDX);
  assign word      = {sh, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      idx <= '0;
    end else if (clr) begin
      sh  <= '0;
      idx <= '0;
    end else if (en) begin
      sh  <= {sh[15:0], din};
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte loader for the instruction memory; holds the core in reset
// while loading. Define PROG_LOADER_CSUM_EN to require the CSUM byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int IW    = 32
) (
  input  logic         clk,
  input  logic         sys_rst,
  prog_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_LEN  = 3'(LEN);
  localparam logic [2:0] S_DATA = 3'(DATA);
  localparam logic [2:0] S_DONE = 3'(DONE);
  localparam logic [2:0] S_ERR  = 3'(ERR);
`ifdef PROG_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'(CSUM);
`endif

  logic [2:0]    state;
  logic [AW-1:0] widx;
  logic [AW-1:0] last;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]    csum;
`endif

  logic          acc;
  logic          sync;
  logic          len_bad;
  logic          pk_clr;
  logic          pk_en;
  logic          pk_done;
  logic [IW-1:0] pk_word;

  assign bus.in_ready = 1'b1;

  assign acc     = bus.in_valid && bus.in_ready;
  assign sync    = bus.in_data == SYNC_BYTE;
  assign len_bad = (bus.in_data == 8'd0) ||
                   (int'(bus.in_data) > DEPTH);
  assign pk_clr  = acc && (state == S_LEN);
  assign pk_en   = acc && (state == S_DATA);

  byte_packer u_pack (
    .clk       (clk),
    .rst       (sys_rst),
    .clr       (pk_clr),
    .en        (pk_en),
    .din       (bus.in_data),
    .word_done (pk_done),
    .word      (pk_word)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      widx          <= '0;
      last          <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum          <= '0;
`endif
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rst   <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (acc) begin
        unique case (state)
          S_LEN: begin
            if (len_bad) begin
              state   <= S_ERR;
              bus.err <= 1'b1;
            end else begin
              state <= S_DATA;
              widx  <= '0;
              last  <= AW'(bus.in_data - 8'd1);
`ifdef PROG_LOADER_CSUM_EN
              csum  <= bus.in_data;
`endif
            end
          end
          S_DATA: begin
`ifdef PROG_LOADER_CSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            if (pk_done) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= widx;
              bus.mem_wdata <= pk_word;
              widx          <= widx + 1'b1;
              if (widx == last) begin
`ifdef PROG_LOADER_CSUM_EN
                state <= S_CSUM;
`else
                state       <= S_DONE;
                bus.done    <= 1'b1;
                bus.cpu_rst <= 1'b0;
`endif
              end
            end
          end
`ifdef PROG_LOADER_CSUM_EN
          S_CSUM: begin
            if (bus.in_data == csum) begin
              state       <= S_DONE;
              bus.done    <= 1'b1;
              bus.cpu_rst <= 1'b0;
            end else begin
              state   <= S_ERR;
              bus.err <= 1'b1;
            end
          end
`endif
          // IDLE, DONE and ERR all restart only on SYNC
          default: begin
            if (sync) begin
              state       <= S_LEN;
              bus.cpu_rst <= 1'b1;
              bus.done    <= 1'b0;
              bus.err     <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, timing sequences,
// and randomized frames against a frame-level reference parser.
module tb_prog_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b[16];
    bit          dn;
    bit          er;
    int          nwr;
    logic [31:0] w0;
  } vec_t;

  logic clk;
  logic sys_rst;

  prog_loader_if #(.AW(4), .IW(32)) bus ();

  prog_loader dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int   checks;
  int   failures;
  wr_t  got[$];
  int   we_wide;
  logic prev_we;
  vec_t vt[8];
  int   nv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) got.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_we === 1'b1 && prev_we === 1'b1) we_wide++;
    prev_we = bus.mem_we;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    sys_rst      = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    got.delete();
    we_wide = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick(gap);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_q(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) send(s[i], $urandom_range(0, maxgap));
  endtask

  // Frame-level reading of the byte stream: writes in order, final flags.
  task automatic model(input logic [7:0] s[$], output wr_t w[$],
                       output bit d, output bit e, output bit c);
    int i;
    int n;
    logic [7:0] cs;
    logic [31:0] wd;
    bit cut;
    w = {};
    d = 0;
    e = 0;
    c = 1;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      d = 0;
      e = 0;
      c = 1;
      i++;
      if (i >= s.size()) break;
      n = int'(s[i]);
      i++;
      if (n < 1 || n > 16) begin
        e = 1;
        continue;
      end
      cs  = 8'(n);
      cut = 0;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > s.size()) begin
          cut = 1;
          break;
        end
        wd = {s[i], s[i+1], s[i+2], s[i+3]};
        cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
        w.push_back({4'(k), wd});
        i += 4;
      end
      if (cut) break;
`ifdef PROG_LOADER_CSUM_EN
      if (i >= s.size()) break;
      if (s[i] == cs) begin
        d = 1;
        c = 0;
      end else begin
        e = 1;
      end
      i++;
`else
      d = 1;
      c = 0;
`endif
    end
  endtask

  task automatic add_frame(inout logic [7:0] s[$], input int len,
                           input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'(len);
    s.push_back(SYNC);
    s.push_back(8'(len));
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom);
      cs ^= b;
      s.push_back(b);
    end
`ifdef PROG_LOADER_CSUM_EN
    s.push_back(bad ? (cs ^ 8'h01) : cs);
`else
    if (bad) s.push_back(8'h3C);
`endif
  endtask

  task automatic run_model(input string nm, input logic [7:0] s[$],
                           input int maxgap);
    wr_t exp[$];
    bit d, e, c;
    do_reset();
    send_q(s, maxgap);
    tick(3);
    model(s, exp, d, e, c);
    chk({nm, "_nwr"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size()) chk({nm, "_wr"}, got[i], exp[i]);
    chk({nm, "_done"}, bus.done, d);
    chk({nm, "_err"}, bus.err, e);
    chk({nm, "_cpu_rst"}, bus.cpu_rst, c);
    chk({nm, "_we_wide"}, we_wide, 0);
  endtask

  task automatic add_vec(input string nm, input logic [7:0] q[$],
                         input bit dn, input bit er, input int nwr,
                         input logic [31:0] w0);
    vt[nv].name = nm;
    vt[nv].n    = q.size();
    foreach (q[i]) vt[nv].b[i] = q[i];
    vt[nv].dn  = dn;
    vt[nv].er  = er;
    vt[nv].nwr = nwr;
    vt[nv].w0  = w0;
    nv++;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s[$];
    logic [7:0] cs;
    bit bad_cs_err;

    checks   = 0;
    failures = 0;
    nv       = 0;
    we_wide  = 0;
    prev_we  = 1'b0;
    sys_rst  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
`ifdef PROG_LOADER_CSUM_EN
    bad_cs_err = 1;
`else
    bad_cs_err = 0;
`endif

    // reset values
    tick(2);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);

    // vector table
    q = {8'hA5, 8'h02, 8'h08, 8'h41, 8'h00, 8'h05,
         8'hD8, 8'h00, 8'h00, 8'h00, 8'h96};
    add_vec("good", q, 1, 0, 2, 32'h08410005);
    q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h08, 8'h41,
         8'h00, 8'h05, 8'hD8, 8'h00, 8'h00, 8'h00, 8'h96};
    add_vec("garbage", q, 1, 0, 2, 32'h08410005);
    q = {8'hA5, 8'h02, 8'h08, 8'h41, 8'h00, 8'h05,
         8'hD8, 8'h00, 8'h00, 8'h00, 8'h97};
    add_vec("bad_csum", q, !bad_cs_err, bad_cs_err, 2, 32'h08410005);
    q = {8'hA5, 8'h00};
    add_vec("len0", q, 0, 1, 0, 32'h0);
    q = {8'hA5, 8'h11};
    add_vec("len17", q, 0, 1, 0, 32'h0);
    q = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    add_vec("one_word", q, 1, 0, 1, 32'h12345678);
    q = {8'hA5, 8'h10, 8'hAB};
    add_vec("partial", q, 0, 0, 0, 32'h0);

    for (int v = 0; v < nv; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].n; i++) send(vt[v].b[i], 0);
      tick(2);
      chk({vt[v].name, "_done"}, bus.done, vt[v].dn);
      chk({vt[v].name, "_err"}, bus.err, vt[v].er);
      chk({vt[v].name, "_cpu_rst"}, bus.cpu_rst, !vt[v].dn);
      chk({vt[v].name, "_nwr"}, got.size(), vt[v].nwr);
      if (vt[v].nwr > 0 && got.size() > 0)
        chk({vt[v].name, "_w0"}, got[0], {4'd0, vt[v].w0});
    end

    // write and done/cpu_rst timing
    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h08, 0);
    send(8'h41, 0);
    send(8'h00, 0);
    chk("t_we_early", bus.mem_we, 0);
    send(8'h05, 0);
    chk("t_we0", bus.mem_we, 1);
    chk("t_addr0", bus.mem_addr, 0);
    chk("t_data0", bus.mem_wdata, 32'h08410005);
    tick(1);
    chk("t_we0_fall", bus.mem_we, 0);
    send(8'hD8, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("t_we1", bus.mem_we, 1);
    chk("t_addr1", bus.mem_addr, 1);
    chk("t_data1", bus.mem_wdata, 32'hD8000000);
`ifdef PROG_LOADER_CSUM_EN
    chk("t_done_before_cs", bus.done, 0);
    send(8'h96, 0);
`endif
    chk("t_done", bus.done, 1);
    chk("t_cpu_rst_low", bus.cpu_rst, 0);
    send(8'h33, 0);
    chk("t_done_hold", bus.done, 1);
    send(SYNC, 0);
    chk("t_sync_cpu_rst", bus.cpu_rst, 1);
    chk("t_sync_done", bus.done, 0);

    // error recovery
    do_reset();
    q = {8'hA5, 8'h00};
    send_q(q, 0);
    chk("rec_err", bus.err, 1);
    chk("rec_err_cpu_rst", bus.cpu_rst, 1);
    q = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_q(q, 0);
    tick(1);
    chk("rec_err_clr", bus.err, 0);
    chk("rec_done", bus.done, 1);

    // full depth
    do_reset();
    s = {SYNC, 8'h10};
    cs = 8'h10;
    for (int i = 0; i < 64; i++) begin
      s.push_back(8'(i * 3 + 1));
      cs ^= 8'(i * 3 + 1);
    end
`ifdef PROG_LOADER_CSUM_EN
    s.push_back(cs);
`endif
    send_q(s, 1);
    tick(2);
    chk("full_nwr", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      chk("full_wr", got[k],
          {4'(k), 8'(12 * k + 1), 8'(12 * k + 4),
           8'(12 * k + 7), 8'(12 * k + 10)});
    chk("full_done", bus.done, 1);
    chk("full_we_wide", we_wide, 0);

    // reset mid-frame
    do_reset();
    q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(q, 0);
    sys_rst = 1'b1;
    #1;
    chk("mrst_mem_we", bus.mem_we, 0);
    chk("mrst_mem_addr", bus.mem_addr, 0);
    chk("mrst_mem_wdata", bus.mem_wdata, 0);
    chk("mrst_cpu_rst", bus.cpu_rst, 1);
    chk("mrst_done", bus.done, 0);
    chk("mrst_err", bus.err, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    tick(1);
    sys_rst = 1'b0;
    got.delete();
    q = {8'hA5, 8'h02, 8'h08, 8'h41, 8'h00, 8'h05,
         8'hD8, 8'h00, 8'h00, 8'h00, 8'h96};
    send_q(q, 0);
    tick(1);
    chk("mrst_nwr", got.size(), 2);
    if (got.size() > 0) chk("mrst_w0", got[0], {4'd0, 32'h08410005});
    chk("mrst_done_after", bus.done, 1);

    // randomized frames, with and without input gaps
    for (int r = 0; r < 8; r++) begin
      s = {};
      for (int f = 0; f < 3; f++) begin
        int g;
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) begin
          logic [7:0] b;
          b = 8'($urandom);
          s.push_back(b == SYNC ? 8'h00 : b);
        end
        if ($urandom_range(0, 7) == 0)
          s = {s, SYNC, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h11};
        else
          add_frame(s, $urandom_range(1, 16), $urandom_range(0, 4) == 0);
      end
      run_model($sformatf("rnd%0d_gap", r), s, 3);
      run_model($sformatf("rnd%0d_nogap", r), s, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
